// File: rtl/hpss_pkg.sv
// Shared constants, state encoding and saturation helper for the HPSS
// overlap-add synthesis stage.
package hpss_pkg;

  localparam int FFT_LEN_C   = 1024;
  localparam int FRAME_LEN_C = 512;
  localparam int HOP_C       = 256;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2
  } hpss_state_e;

  // Clamp a signed 32-bit value into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'h7FFF;
    else if (v < -32'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/hpss_ola_ram.sv
// Overlap buffer: simple dual-port RAM, synchronous read and write, no reset
// on contents.
module hpss_ola_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/hpss_overlap_add.sv
// 50 % overlap-add of iFFT frames into a continuous 16-bit stream feeding the
// output FIFO write port.
module hpss_overlap_add
  import hpss_pkg::*;
#(
  parameter int FFT_LEN   = FFT_LEN_C,
  parameter int FRAME_LEN = FRAME_LEN_C,
  parameter int HOP       = HOP_C,
  parameter int SHIFT     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start,
  output logic        busy,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        out_en,
  output logic [15:0] out_data,
  output logic        finsh,
  output hpss_state_e state_dbg
);

  localparam int IW = $clog2(FFT_LEN);
  localparam int AW = $clog2(HOP);
  localparam logic [IW-1:0] HOP_I   = IW'(HOP);
  localparam logic [IW-1:0] FRAME_I = IW'(FRAME_LEN);
  localparam logic [IW-1:0] LAST_I  = IW'(FFT_LEN - 1);
  localparam logic [AW-1:0] LAST_A  = AW'(HOP - 1);

  hpss_state_e state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] clr_cnt_q;
  logic          rel_q;
  logic          acc_q, wr_q, finsh_q, out_en_q;
  logic [15:0]   s16_q, out_data_q;
  logic [AW-1:0] waddr_q;

  logic          accept, clr_we, rd_en;
  logic [15:0]   rd_data;
  logic signed [31:0] scaled;
  logic signed [16:0] sum17;
  logic          unused_hi;

  assign unused_hi = ^in_data[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // rel_q gates the clear sweep so busy covers a full HOP cycles after reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (rel_q && clr_cnt_q == LAST_A) state_d = IDLE;
      IDLE: begin
        if (clear)      state_d = CLEAR;
        else if (start) state_d = RUN;
      end
      RUN: begin
        if (clear)                          state_d = CLEAR;
        else if (in_valid && idx_q == LAST_I) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    accept = (state_q == RUN) && in_valid && !clear;
    clr_we = (state_q == CLEAR) && rel_q;
    rd_en  = accept && (idx_q < HOP_I);
    busy   = rel_q && (state_q != IDLE);
  end

  assign scaled = $signed(in_data[31:0]) >>> SHIFT;
  assign sum17  = $signed({s16_q[15], s16_q}) + $signed({rd_data[15], rd_data});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q      <= 1'b0;
      clr_cnt_q  <= '0;
      idx_q      <= '0;
      acc_q      <= 1'b0;
      wr_q       <= 1'b0;
      s16_q      <= '0;
      waddr_q    <= '0;
      finsh_q    <= 1'b0;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      rel_q     <= 1'b1;
      clr_cnt_q <= clr_we ? clr_cnt_q + 1'b1 : '0;
      if (state_q != RUN) idx_q <= '0;
      else if (accept)    idx_q <= idx_q + 1'b1;
      acc_q   <= rd_en;
      wr_q    <= accept && (idx_q >= HOP_I) && (idx_q < FRAME_I);
      finsh_q <= accept && (idx_q == LAST_I);
      if (accept) begin
        s16_q   <= sat16(scaled);
        waddr_q <= idx_q[AW-1:0];
      end
      out_en_q <= acc_q;
      if (acc_q) out_data_q <= sat16({{15{sum17[16]}}, sum17});
    end
  end

  hpss_ola_ram #(.DEPTH(HOP), .AW(AW), .DW(16)) u_ram (
    .clk     (clk),
    .we_i    (clr_we | wr_q),
    .waddr_i (clr_we ? clr_cnt_q : waddr_q),
    .wdata_i (clr_we ? 16'h0000 : s16_q),
    .re_i    (rd_en),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign out_en    = out_en_q;
  assign out_data  = out_data_q;
  assign finsh     = finsh_q;
  assign state_dbg = state_q;

endmodule
